// File: rtl/te_pkg.sv
// Shared constants for the temporal encoder.
// Default delay-code width used by te and its counter.
package te_pkg;

  localparam int unsigned TE_BITS_DEF = 4;

endpackage

// File: rtl/te_down_counter.sv
// Loadable down-counter for the temporal encoder.
// term_o flags the last cycle of a pending delay.
module te_down_counter
  import te_pkg::*;
#(
  parameter int unsigned BITS = TE_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            dec_i,
  input  logic [BITS-1:0] din_i,
  output logic [BITS-1:0] cnt_o,
  output logic            term_o
);

  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = din_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == {{(BITS-1){1'b0}}, 1'b1});

endmodule

// File: rtl/te.sv
// Temporal encoder: replays each tin level change on tout
// din clock cycles after the edge that samples it.
module te
  import te_pkg::*;
#(
  parameter int unsigned BITS = TE_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tin,
  input  logic [BITS-1:0] din,
  output logic            tout
);

  logic            tout_q;
  logic            tout_d;
  logic            busy_q;
  logic            busy_d;
  logic            load;
  logic            dec;
  logic            term;
  logic [BITS-1:0] cnt;

  te_down_counter #(
    .BITS (BITS)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .dec_i  (dec),
    .din_i  (din),
    .cnt_o  (cnt),
    .term_o (term)
  );

  // tin and din are only looked at while idle
  always_comb begin
    tout_d = tout_q;
    busy_d = busy_q;
    load   = 1'b0;
    dec    = 1'b0;
    if (!busy_q) begin
      if (tin != tout_q) begin
        if (din == '0) begin
          tout_d = tin;
        end else begin
          load   = 1'b1;
          busy_d = 1'b1;
        end
      end
    end else if (term) begin
      tout_d = ~tout_q;
      busy_d = 1'b0;
    end else begin
      dec = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tout_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      tout_q <= tout_d;
      busy_q <= busy_d;
    end
  end

  assign tout = tout_q;

endmodule

// File: tb/tb_te.sv
// Directed self-checking bench for te.
// Inputs change 1 time unit after each rising edge.
module tb_te;

  logic       clk;
  logic       rst;
  logic       tin;
  logic [3:0] din;
  logic       tout;

  int n_run;
  int n_fail;

  te #(
    .BITS (4)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .tin  (tin),
    .din  (din),
    .tout (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b exp %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // tin was just changed to lvl; next edge is E0
  task automatic observe(input string tag, input int d,
                         input logic lvl, input int span);
    for (int k = 0; k < span; k++) begin
      step();
      chk($sformatf("%s d=%0d k=%0d", tag, d, k), tout,
          (k >= d) ? lvl : ~lvl);
    end
  endtask

  logic lv;

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    tin    = 1'b1;
    din    = 4'd5;

    // reset holds tout low even with tin high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", tout, 1'b0);
    end
    rst = 1'b0;
    observe("rst_rel", 5, 1'b1, 7);

    // delay sweep, both edge directions
    for (int d = 0; d < 16; d++) begin
      din = 4'(d);
      tin = ~tin;
      observe("sweep", d, tin, 17);
    end

    // zero code follows at the sampling edge
    din = 4'd0;
    tin = ~tin;
    observe("zero", 0, tin, 2);
    tin = ~tin;
    observe("zero", 0, tin, 2);

    // code change while busy is ignored
    lv  = ~tin;
    din = 4'd12;
    tin = lv;
    step();
    chk("mid k=0", tout, ~lv);
    din = 4'd2;
    for (int k = 1; k < 15; k++) begin
      step();
      chk($sformatf("mid k=%0d", k), tout, (k >= 12) ? lv : ~lv);
    end
    tin = ~tin;
    observe("mid_next", 2, tin, 4);

    // short pulse is stretched, return edge uses new din
    lv  = tin;
    din = 4'd8;
    tin = ~lv;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("pulse k=%0d", k), tout, lv);
    end
    tin = lv;
    din = 4'd3;
    for (int k = 3; k < 14; k++) begin
      step();
      chk($sformatf("pulse k=%0d", k), tout,
          (k >= 8 && k < 12) ? ~lv : lv);
    end

    // reset in the middle of a delay
    din = 4'd10;
    tin = ~tin;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    chk("rst_mid tout", tout, 1'b0);
    chk("rst_mid busy", u_dut.busy_q, 1'b0);
    rst = 1'b0;
    tin = 1'b0;
    for (int k = 5; k < 13; k++) begin
      step();
      chk($sformatf("rst_mid k=%0d", k), tout, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
